// File: rtl/ehgu_fifo_pkg.sv
// Shared width helpers, per-channel state view and address arithmetic for the
// multi-channel FIFO controller.
package ehgu_fifo_pkg;

   // Wide enough for any practical DEPTH; narrowed back at the point of use.
   localparam int ST_W = 16;

   function automatic int chw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic int pw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int maw(input int nch, input int depth);
      return ((nch * depth) > 1) ? $clog2(nch * depth) : 1;
   endfunction

   typedef struct packed {
      logic [ST_W-1:0] wptr;
      logic [ST_W-1:0] rptr;
      logic [ST_W-1:0] count;
   } fifo_chan_state_t;

   function automatic int addr_calc(input int ch, input int ptr, input int depth);
      return ch * depth + ptr;
   endfunction

endpackage

// File: rtl/ehgu_fifo_ctrl_mc_if.sv
// Request/accept handshake, memory port and read-return signals of the
// multi-channel FIFO controller.
interface ehgu_fifo_ctrl_mc_if
   import ehgu_fifo_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DEPTH = 12
);
   localparam int CHW = chw(NCH);
   localparam int MAW = maw(NCH, DEPTH);

   logic           wr_valid;
   logic [CHW-1:0] wr_ch;
   logic           wr_accept;
   logic           rd_req;
   logic [CHW-1:0] rd_ch;
   logic           rd_accept;
   logic           mem_wenable;
   logic [MAW-1:0] mem_waddr;
   logic           mem_renable;
   logic [MAW-1:0] mem_raddr;
   logic           dout_valid;
   logic [CHW-1:0] dout_ch;

   modport master (
      output wr_valid, wr_ch, rd_req, rd_ch,
      input  wr_accept, rd_accept, mem_wenable, mem_waddr,
      input  mem_renable, mem_raddr, dout_valid, dout_ch
   );

   modport slave (
      input  wr_valid, wr_ch, rd_req, rd_ch,
      output wr_accept, rd_accept, mem_wenable, mem_waddr,
      output mem_renable, mem_raddr, dout_valid, dout_ch
   );

endinterface

// File: rtl/ehgu_fifo_chan_state.sv
// One channel's pointers, occupancy and registered status flags; flags are
// computed from the next-state count so they line up with the new count.
module ehgu_fifo_chan_state
   import ehgu_fifo_pkg::*;
#(
   parameter  int DEPTH     = 12,
   parameter  int AFULL_TH  = DEPTH - 2,
   parameter  int AEMPTY_TH = 2,
   localparam int PW        = pw(DEPTH),
   localparam int CW        = cw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   output logic [PW-1:0] wptr,
   output logic [PW-1:0] rptr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty
);

   logic [PW-1:0] wptr_nxt;
   logic [PW-1:0] rptr_nxt;
   logic [CW-1:0] count_nxt;

   always_comb begin
      wptr_nxt  = wptr;
      rptr_nxt  = rptr;
      count_nxt = count;
      if (flush) begin
         wptr_nxt  = '0;
         rptr_nxt  = '0;
         count_nxt = '0;
      end else begin
         // Explicit wrap compare: DEPTH need not be a power of two.
         if (push) wptr_nxt = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
         if (pop)  rptr_nxt = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
         case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wptr         <= wptr_nxt;
         rptr         <= rptr_nxt;
         count        <= count_nxt;
         full         <= (count_nxt == CW'(DEPTH));
         empty        <= (count_nxt == '0);
         almost_full  <= (int'(count_nxt) >= AFULL_TH);
         almost_empty <= (int'(count_nxt) <= AEMPTY_TH);
      end
   end

endmodule

// File: rtl/ehgu_fifo_ctrl_mc.sv
// Multi-channel FIFO controller driving one shared external SDP memory split
// into NCH regions; holds pointers and status only, never the data.
module ehgu_fifo_ctrl_mc
   import ehgu_fifo_pkg::*;
#(
   parameter  int NCH       = 4,
   parameter  int DEPTH     = 12,
   parameter  int RD_LAT    = 1,
   parameter  int AFULL_TH  = DEPTH - 2,
   parameter  int AEMPTY_TH = 2,
   localparam int CHW       = chw(NCH),
   localparam int PW        = pw(DEPTH),
   localparam int CW        = cw(DEPTH),
   localparam int MAW       = maw(NCH, DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   ehgu_fifo_ctrl_mc_if.slave    bus,
   input  logic [NCH-1:0]        flush,
   output logic [NCH-1:0]        full,
   output logic [NCH-1:0]        empty,
   output logic [NCH-1:0]        almost_full,
   output logic [NCH-1:0]        almost_empty,
   output logic [NCH*CW-1:0]     count,
   output logic                  err_ovf,
   output logic                  err_udf,
   input  logic                  err_clr
);

   logic [PW-1:0]    wptr [NCH];
   logic [PW-1:0]    rptr [NCH];
   logic [CW-1:0]    cnt  [NCH];
   fifo_chan_state_t cs   [NCH];
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop;
   logic             wr_ch_ok;
   logic             rd_ch_ok;
   logic [CHW-1:0]   wr_idx;
   logic [CHW-1:0]   rd_idx;
   logic             wr_room;
   logic             rd_avail;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      ehgu_fifo_chan_state #(
         .DEPTH     (DEPTH),
         .AFULL_TH  (AFULL_TH),
         .AEMPTY_TH (AEMPTY_TH)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .push         (push[i]),
         .pop          (pop[i]),
         .flush        (flush[i]),
         .wptr         (wptr[i]),
         .rptr         (rptr[i]),
         .count        (cnt[i]),
         .full         (full[i]),
         .empty        (empty[i]),
         .almost_full  (almost_full[i]),
         .almost_empty (almost_empty[i])
      );
      assign count[i*CW +: CW] = cnt[i];
      assign cs[i] = '{wptr: ST_W'(wptr[i]), rptr: ST_W'(rptr[i]), count: ST_W'(cnt[i])};
   end

   // Out-of-range channels are steered to channel 0 and then refused.
   assign wr_ch_ok = int'(bus.wr_ch) < NCH;
   assign rd_ch_ok = int'(bus.rd_ch) < NCH;
   assign wr_idx   = wr_ch_ok ? bus.wr_ch : '0;
   assign rd_idx   = rd_ch_ok ? bus.rd_ch : '0;

   // The registered full/empty flags always equal these count compares.
   assign wr_room  = int'(cs[wr_idx].count) != DEPTH;
   assign rd_avail = int'(cs[rd_idx].count) != 0;

   assign bus.wr_accept   = bus.wr_valid && wr_ch_ok && wr_room && !flush[wr_idx];
   assign bus.rd_accept   = bus.rd_req && rd_ch_ok && rd_avail && !flush[rd_idx];
   assign bus.mem_wenable = bus.wr_accept;
   assign bus.mem_renable = bus.rd_accept;
   assign bus.mem_waddr   = MAW'(addr_calc(int'(wr_idx), int'(cs[wr_idx].wptr), DEPTH));
   assign bus.mem_raddr   = MAW'(addr_calc(int'(rd_idx), int'(cs[rd_idx].rptr), DEPTH));

   always_comb begin
      push = '0;
      pop  = '0;
      if (bus.wr_accept) push[wr_idx] = 1'b1;
      if (bus.rd_accept) pop[rd_idx]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (bus.wr_valid && !bus.wr_accept) err_ovf <= 1'b1;
         else if (err_clr)                   err_ovf <= 1'b0;
         if (bus.rd_req && !bus.rd_accept)   err_udf <= 1'b1;
         else if (err_clr)                   err_udf <= 1'b0;
      end
   end

   // Read-return tag pipeline, matching the memory's read latency.
   logic [RD_LAT-1:0] pipe_v;
   logic [CHW-1:0]    pipe_ch [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
         for (int k = 0; k < RD_LAT; k++) pipe_ch[k] <= '0;
      end else begin
         pipe_v[0]  <= bus.rd_accept;
         pipe_ch[0] <= rd_idx;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_v[k]  <= pipe_v[k-1];
            pipe_ch[k] <= pipe_ch[k-1];
         end
      end
   end

   assign bus.dout_valid = pipe_v[RD_LAT-1];
   assign bus.dout_ch    = pipe_ch[RD_LAT-1];

endmodule

// File: tb/tb_ehgu_fifo_ctrl_mc.sv
// Self-checking bench: behavioural channel model for accepts/addresses/flags
// plus a read-return scoreboard for dout_valid/dout_ch timing.
module tb_ehgu_fifo_ctrl_mc;
   import ehgu_fifo_pkg::*;

   localparam int NCH       = 4;
   localparam int DEPTH     = 12;
   localparam int RD_LAT    = 3;
   localparam int AFULL_TH  = 10;
   localparam int AEMPTY_TH = 2;
   localparam int CW        = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   flush;
   logic [NCH-1:0]   full, empty, almost_full, almost_empty;
   logic [NCH*CW-1:0] count;
   logic             err_ovf, err_udf, err_clr;

   always #5 clk = ~clk;

   ehgu_fifo_ctrl_mc_if #(.NCH(NCH), .DEPTH(DEPTH)) bus ();

   ehgu_fifo_ctrl_mc #(
      .NCH(NCH), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
      .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .flush        (flush),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .err_ovf      (err_ovf),
      .err_udf      (err_udf),
      .err_clr      (err_clr)
   );

   typedef struct {int ch; int due;} rd_t;
   rd_t sb[$];
   int  m_wp [NCH];
   int  m_rp [NCH];
   int  m_cnt[NCH];
   bit  m_ovf, m_udf;
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Read-return monitor: every dout_valid must match the oldest pending read.
   always @(negedge clk) begin
      if (bus.dout_valid === 1'b1) begin
         if (sb.size() == 0) chk("dout_spurious", 1, 0);
         else begin
            rd_t e;
            e = sb.pop_front();
            chk("dout_ch", int'(bus.dout_ch), e.ch);
            chk("dout_cycle", cyc, e.due);
         end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
         chk("dout_missing", 0, 1);
         void'(sb.pop_front());
      end
   end

   task automatic check_state();
      logic [NCH-1:0]    ef, ee, eaf, eae;
      logic [NCH*CW-1:0] ec;
      for (int i = 0; i < NCH; i++) begin
         ef[i]  = (m_cnt[i] == DEPTH);
         ee[i]  = (m_cnt[i] == 0);
         eaf[i] = (m_cnt[i] >= AFULL_TH);
         eae[i] = (m_cnt[i] <= AEMPTY_TH);
         ec[i*CW +: CW] = CW'(m_cnt[i]);
      end
      chk("full", int'(full), int'(ef));
      chk("empty", int'(empty), int'(ee));
      chk("almost_full", int'(almost_full), int'(eaf));
      chk("almost_empty", int'(almost_empty), int'(eae));
      chk("count", int'(count), int'(ec));
      chk("err_ovf", int'(err_ovf), int'(m_ovf));
      chk("err_udf", int'(err_udf), int'(m_udf));
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic step(input logic wv, input logic [1:0] wch, input logic rr,
                       input logic [1:0] rch, input logic [NCH-1:0] fl, input logic ec);
      bit ewa, era;
      bus.wr_valid = wv; bus.wr_ch = wch;
      bus.rd_req   = rr; bus.rd_ch = rch;
      flush = fl; err_clr = ec;
      #1;
      ewa = wv && (m_cnt[wch] != DEPTH) && !fl[wch];
      era = rr && (m_cnt[rch] != 0) && !fl[rch];
      chk("wr_accept", int'(bus.wr_accept), int'(ewa));
      chk("rd_accept", int'(bus.rd_accept), int'(era));
      chk("mem_wenable", int'(bus.mem_wenable), int'(ewa));
      chk("mem_renable", int'(bus.mem_renable), int'(era));
      if (ewa) chk("mem_waddr", int'(bus.mem_waddr), int'(wch) * DEPTH + m_wp[wch]);
      if (era) begin
         chk("mem_raddr", int'(bus.mem_raddr), int'(rch) * DEPTH + m_rp[rch]);
         sb.push_back('{ch: int'(rch), due: cyc + RD_LAT});
      end
      @(posedge clk);
      if (wv && !ewa) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
      if (rr && !era) m_udf = 1'b1; else if (ec) m_udf = 1'b0;
      if (ewa) begin
         m_wp[wch] = (m_wp[wch] == DEPTH - 1) ? 0 : m_wp[wch] + 1;
         m_cnt[wch]++;
      end
      if (era) begin
         m_rp[rch] = (m_rp[rch] == DEPTH - 1) ? 0 : m_rp[rch] + 1;
         m_cnt[rch]--;
      end
      for (int i = 0; i < NCH; i++)
         if (fl[i]) begin m_wp[i] = 0; m_rp[i] = 0; m_cnt[i] = 0; end
      @(negedge clk);
      check_state();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.wr_valid = 1'b0; bus.wr_ch = '0; bus.rd_req = 1'b0; bus.rd_ch = '0;
      flush = '0; err_clr = 1'b0;
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NCH; i++) begin m_wp[i] = 0; m_rp[i] = 0; m_cnt[i] = 0; end
      m_ovf = 1'b0; m_udf = 1'b0;
      check_state();
      chk("reset_dout_valid", int'(bus.dout_valid), 0);
      chk("reset_dout_ch", int'(bus.dout_ch), 0);
   endtask

   initial begin
      do_reset();

      // Read from an empty channel: refused, underflow latched, then cleared.
      step(1'b0, 2'd0, 1'b1, 2'd2, '0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b1);

      // Fill ch1 (addresses 12..23), 13th write refused with overflow.
      for (int k = 0; k < 13; k++) step(1'b1, 2'd1, 1'b0, 2'd0, '0, 1'b0);
      chk("ch1_full", int'(full[1]), 1);
      step(1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b1);

      // ch3 fill, drain, one more write lands on address 36 (pointer wrap).
      for (int k = 0; k < 12; k++) step(1'b1, 2'd3, 1'b0, 2'd0, '0, 1'b0);
      for (int k = 0; k < 12; k++) step(1'b0, 2'd0, 1'b1, 2'd3, '0, 1'b0);
      bus.wr_valid = 1'b1; bus.wr_ch = 2'd3; #1;
      chk("wrap_waddr", int'(bus.mem_waddr), 36);
      step(1'b1, 2'd3, 1'b0, 2'd0, '0, 1'b0);
      idle(RD_LAT);

      // ch0 to 5, simultaneous write+read on ch0, then write ch0 + read ch1.
      for (int k = 0; k < 5; k++) step(1'b1, 2'd0, 1'b0, 2'd0, '0, 1'b0);
      step(1'b1, 2'd0, 1'b1, 2'd0, '0, 1'b0);
      chk("same_ch_count", int'(count[0 +: CW]), 5);
      step(1'b1, 2'd0, 1'b1, 2'd1, '0, 1'b0);
      chk("cross_ch0", int'(count[0 +: CW]), 6);
      chk("cross_ch1", int'(count[CW +: CW]), 11);

      // Full channel: write blocked, read in the same cycle still proceeds.
      step(1'b1, 2'd1, 1'b0, 2'd0, '0, 1'b0);
      step(1'b1, 2'd1, 1'b1, 2'd1, '0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b1);
      idle(RD_LAT);

      // Back-to-back reads on ch 0,2,1 return in order at full throughput.
      step(1'b1, 2'd2, 1'b0, 2'd0, '0, 1'b0);
      step(1'b1, 2'd2, 1'b0, 2'd0, '0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 2'd0, '0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 2'd2, '0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 2'd1, '0, 1'b0);
      idle(RD_LAT + 1);

      // ch2 to 7, flush with a same-cycle write, set beats clear, then clear.
      for (int k = 0; k < 6; k++) step(1'b1, 2'd2, 1'b0, 2'd0, '0, 1'b0);
      chk("ch2_pre_flush", int'(count[2*CW +: CW]), 7);
      step(1'b1, 2'd2, 1'b0, 2'd0, 4'b0100, 1'b0);
      chk("flush_empty2", int'(empty[2]), 1);
      step(1'b1, 2'd2, 1'b0, 2'd0, 4'b0100, 1'b1);
      step(1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b1);

      // Reset with a read in flight: its dout_valid must never appear.
      step(1'b0, 2'd0, 1'b1, 2'd0, '0, 1'b0);
      do_reset();
      idle(RD_LAT + 2);

      // Random traffic with occasional flushes and error clears.
      for (int k = 0; k < 400; k++) begin
         logic [NCH-1:0] fl;
         fl = ($urandom_range(0, 19) == 0) ? NCH'($urandom_range(1, 15)) : '0;
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              fl, 1'($urandom_range(0, 7) == 0));
      end

      idle(RD_LAT + 2);
      chk("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ehgu_fifo_ctrl_mc.md
Name: ehgu_fifo_ctrl_mc

Overview:
Single-clock, multi-channel FIFO controller with no storage of its own. It drives one external simple-dual-port memory that is partitioned into NCH regions of DEPTH words. Each channel keeps its own pointers, occupancy count, status flags and flush. Adds behaviour the single-channel logic lacks: backpressure, full/almost-full/almost-empty flags, sticky overflow/underflow errors, configurable memory read latency and per-channel flush.

Parameters:
NCH, 4, number of logical channels (>=1)
DEPTH, 12, words per channel; any value >=2, power of two not required
RD_LAT, 1, memory read latency in clk cycles (>=1)
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH
CHW, derived: max(1,$clog2(NCH))
PW, derived: max(1,$clog2(DEPTH))
CW, derived: $clog2(DEPTH+1)
MAW, derived: max(1,$clog2(NCH*DEPTH))

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request
wr_ch  in  CHW  target channel of write
wr_accept  out  1  combinational: wr_valid && !full[wr_ch] && !flush[wr_ch] && wr_ch<NCH
rd_req  in  1  read request
rd_ch  in  CHW  source channel of read
rd_accept  out  1  combinational: rd_req && !empty[rd_ch] && !flush[rd_ch] && rd_ch<NCH
flush  in  NCH  per-channel synchronous clear
mem_wenable  out  1  equals wr_accept
mem_waddr  out  MAW  wr_ch*DEPTH + wptr[wr_ch]
mem_renable  out  1  equals rd_accept
mem_raddr  out  MAW  rd_ch*DEPTH + rptr[rd_ch]
dout_valid  out  1  memory read data valid, RD_LAT cycles after rd_accept
dout_ch  out  CHW  channel tag aligned with dout_valid
full  out  NCH  count==DEPTH
empty  out  NCH  count==0
almost_full  out  NCH  count>=AFULL_TH
almost_empty  out  NCH  count<=AEMPTY_TH
count  out  NCH*CW  packed per-channel occupancy; channel i in bits [i*CW +: CW]
err_ovf  out  1  sticky: wr_valid seen while not accepted
err_udf  out  1  sticky: rd_req seen while not accepted
err_clr  in  1  clears both error flags

Behaviour:
- Reset (rst=1 at posedge): all wptr/rptr/count=0; empty=all 1; full=0; almost_empty=all 1; almost_full=0; dout_valid=0; dout_ch=0; err_ovf=err_udf=0; latency pipeline cleared. Reset mid-read discards in-flight dout_valid.
- Pointer wrap: ptr==DEPTH-1 advances to 0. No modulo on non-power-of-two widths; use an explicit compare.
- Write accepted: wptr[wr_ch]++ at next edge. Read accepted: rptr[rd_ch]++ at next edge.
- Count per channel: +1 if write only, -1 if read only, unchanged if both target the same channel in the same cycle. A simultaneous write and read are legal when empty or full is not violated by the respective side alone. Full blocks the write; the read still proceeds.
- Flags are registered, derived from the next-state count, and valid the cycle after the update.
- Flush[i]: at the next edge, wptr/rptr/count of channel i go to 0. Flush wins over any same-cycle access to channel i (both accepts low for i). Reads of channel i already in flight still emit dout_valid.
- Errors: err_ovf sets on wr_valid && !wr_accept, including full, flush and illegal channel. err_udf is the read-side equivalent. Set has priority over err_clr in the same cycle.
- Read pipeline: an RD_LAT-deep shift register of {valid, ch}. dout_valid(t+RD_LAT)=rd_accept(t). Back-to-back reads run at full throughput.
- No memory data passes through this block.

Decomposition:
- Package ehgu_fifo_pkg: width functions (chw, pw, cw, maw), typedef fifo_chan_state_t {wptr, rptr, count}, and an addr_calc function (ch*DEPTH+ptr).
- Sub-module ehgu_fifo_chan_state: one per channel (generate loop). Inputs: push, pop, flush. Outputs: pointers, count, four flags. Top-level: accept logic, address mux, error flags, latency pipeline.

Test Plan:
- Reset, NCH=4, DEPTH=12: all empty=4'b1111, count=0; rd_req on ch2 -> rd_accept=0, err_udf=1 next cycle.
- 12 writes to ch1 -> full[1]=1 after the 12th. The 13th gets wr_accept=0 and err_ovf=1. mem_waddr for the 12 writes is 12..23.
- Fill ch3 with 12 writes, read 12, write 1 -> the last write goes to mem_waddr=36, confirming wptr wraps 11->0 (non-power-of-two).
- ch0 count=5, simultaneous write+read on ch0 -> count stays 5. Write ch0 + read ch1 -> counts 6 and n-1.
- RD_LAT=3, reads on cycles 10,11,12 (ch 0,2,1) -> dout_valid on 13,14,15 with dout_ch 0,2,1.
- ch2 count=7, flush[2] plus write to ch2 in the same cycle -> wr_accept=0, count[2]=0, empty[2]=1; other channels unchanged; err_clr then clears err_ovf.
